// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray coding and the full compare.
// Widths up to 32 bits; callers truncate results to their pointer width.
package fifo_pkg;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++)
      b = b ^ (g >> i);
    return b;
  endfunction

  // Full when the top two pointer bits differ and the rest match
  function automatic logic fifo_full(
    input logic [31:0] wg,
    input logic [31:0] rg,
    input int unsigned w
  );
    return wg == (rg ^ (32'd3 << (w - 2)));
  endfunction

endpackage

// File: rtl/fifo_wptr_ctrl_if.sv
// Producer-side bundle of the async FIFO write controller.
// master = producer/FIFO top, slave = controller.
interface fifo_wptr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en_in;
  logic                  clear_ovf_in;
  logic [ADDR_WIDTH:0]   rptr_sync_in;
  logic                  wr_fire_out;
  logic [ADDR_WIDTH-1:0] waddr_out;
  logic [ADDR_WIDTH:0]   wptr_out;
  logic                  wfull_out;
  logic                  almost_full_out;
  logic [ADDR_WIDTH:0]   wr_count_out;
  logic                  overflow_out;

  modport master (
    output wr_en_in, clear_ovf_in, rptr_sync_in,
    input  wr_fire_out, waddr_out, wptr_out,
    input  wfull_out, almost_full_out,
    input  wr_count_out, overflow_out
  );

  modport slave (
    input  wr_en_in, clear_ovf_in, rptr_sync_in,
    output wr_fire_out, waddr_out, wptr_out,
    output wfull_out, almost_full_out,
    output wr_count_out, overflow_out
  );
endinterface

// File: rtl/fifo_wptr_ctrl.sv
// Write-domain pointer / full-flag controller of the async FIFO.
// Flags are pessimistic: read progress arrives via the synchroniser.
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input logic              clk_in,
  input logic              reset_n_in,
  fifo_wptr_ctrl_if.slave  bus
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wptr;
  logic             r_full;
  logic             r_af;
  logic [PTR_W-1:0] r_count;
  logic             r_ovf;

  logic             w_push;
  logic [PTR_W-1:0] w_wbin_next;
  logic [PTR_W-1:0] w_wgray_next;
  logic [PTR_W-1:0] w_rbin;
  logic [PTR_W-1:0] w_count_next;
  logic             w_full_next;
  logic             w_ovf_set;

  // Reset also blocks the RAM write while it is held
  assign w_push = bus.wr_en_in & ~r_full & reset_n_in;
  assign w_ovf_set = bus.wr_en_in & r_full;

  assign w_wbin_next  = r_wbin + PTR_W'(w_push);
  assign w_wgray_next = PTR_W'(bin2gray(32'(w_wbin_next)));
  assign w_rbin       = PTR_W'(gray2bin(32'(bus.rptr_sync_in)));
  assign w_count_next = w_wbin_next - w_rbin;
  assign w_full_next  = fifo_full(32'(w_wgray_next),
                                  32'(bus.rptr_sync_in),
                                  PTR_W);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_wgray_next;
      r_full  <= w_full_next;
      r_af    <= 32'(w_count_next) >= 32'(AF_LEVEL);
      r_count <= w_count_next;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (bus.clear_ovf_in)
        r_ovf <= 1'b0;
    end
  end

  assign bus.wr_fire_out     = w_push;
  assign bus.waddr_out       = r_wbin[ADDR_WIDTH-1:0];
  assign bus.wptr_out        = r_wptr;
  assign bus.wfull_out       = r_full;
  assign bus.almost_full_out = r_af;
  assign bus.wr_count_out    = r_count;
  assign bus.overflow_out    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for fifo_wptr_ctrl (ADDR_WIDTH=4, AF_LEVEL=12).
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_fifo_wptr_ctrl;

  logic clk_in = 1'b0;
  logic reset_n_in = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fifo_wptr_ctrl_if #(.ADDR_WIDTH(4)) bus();

  fifo_wptr_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(12)) dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_n_in = 1'b0;
    bus.wr_en_in = 1'b1;
    bus.clear_ovf_in = 1'b0;
    bus.rptr_sync_in = '0;
    step();
    step();
    checks++;
    if ({bus.wr_fire_out, bus.waddr_out, bus.wptr_out, bus.wfull_out,
         bus.almost_full_out, bus.wr_count_out, bus.overflow_out} !== '0) begin
      failures++;
      $display("FAIL reset_outs: got fire=%b waddr=%0d wptr=%b full=%b af=%b cnt=%0d ovf=%b, want all 0",
               bus.wr_fire_out, bus.waddr_out, bus.wptr_out, bus.wfull_out,
               bus.almost_full_out, bus.wr_count_out, bus.overflow_out);
    end
    reset_n_in = 1'b1;
    bus.wr_en_in = 1'b0;
    #1;
    bus.wr_en_in = 1'b1;
    #1;
    checks++;
    if (bus.wr_fire_out !== 1'b1 || bus.waddr_out !== 4'd0) begin
      failures++;
      $display("FAIL reset_release: fire=%b waddr=%0d, want 1 0",
               bus.wr_fire_out, bus.waddr_out);
    end
    bus.wr_en_in = 1'b0;
  endtask

  task automatic test_fill();
    bus.rptr_sync_in = 5'b00000;
    bus.wr_en_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.waddr_out !== 4'(i) || bus.wr_fire_out !== 1'b1) begin
        failures++;
        $display("FAIL fill_waddr[%0d]: waddr=%0d fire=%b, want %0d 1",
                 i, bus.waddr_out, bus.wr_fire_out, i);
      end
      step();
      if (i == 10) begin
        checks++;
        if (bus.almost_full_out !== 1'b0 || bus.wr_count_out !== 5'd11) begin
          failures++;
          $display("FAIL fill_af11: af=%b cnt=%0d, want 0 11",
                   bus.almost_full_out, bus.wr_count_out);
        end
      end
      if (i == 11) begin
        checks++;
        if (bus.almost_full_out !== 1'b1 || bus.wr_count_out !== 5'd12 ||
            bus.wfull_out !== 1'b0) begin
          failures++;
          $display("FAIL fill_af12: af=%b cnt=%0d full=%b, want 1 12 0",
                   bus.almost_full_out, bus.wr_count_out, bus.wfull_out);
        end
      end
      if (i == 14) begin
        checks++;
        if (bus.wfull_out !== 1'b0) begin
          failures++;
          $display("FAIL fill_early_full: full=%b, want 0", bus.wfull_out);
        end
      end
    end
    checks++;
    if (bus.wfull_out !== 1'b1 || bus.wptr_out !== 5'b11000 ||
        bus.wr_count_out !== 5'd16) begin
      failures++;
      $display("FAIL fill_full: full=%b wptr=%b cnt=%0d, want 1 11000 16",
               bus.wfull_out, bus.wptr_out, bus.wr_count_out);
    end
  endtask

  task automatic test_overflow();
    bus.wr_en_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.wr_fire_out !== 1'b0) begin
        failures++;
        $display("FAIL ovf_fire[%0d]: fire=%b, want 0", i, bus.wr_fire_out);
      end
      step();
      checks++;
      if (bus.wptr_out !== 5'b11000 || bus.overflow_out !== 1'b1 ||
          bus.waddr_out !== 4'd0) begin
        failures++;
        $display("FAIL ovf_hold[%0d]: wptr=%b ovf=%b waddr=%0d, want 11000 1 0",
                 i, bus.wptr_out, bus.overflow_out, bus.waddr_out);
      end
    end
    bus.clear_ovf_in = 1'b1;
    step();
    checks++;
    if (bus.overflow_out !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins: ovf=%b, want 1", bus.overflow_out);
    end
    bus.wr_en_in = 1'b0;
    step();
    bus.clear_ovf_in = 1'b0;
    checks++;
    if (bus.overflow_out !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%b, want 0", bus.overflow_out);
    end
    step();
    checks++;
    if (bus.overflow_out !== 1'b0 || bus.wfull_out !== 1'b1) begin
      failures++;
      $display("FAIL ovf_stay_clear: ovf=%b full=%b, want 0 1",
               bus.overflow_out, bus.wfull_out);
    end
  endtask

  task automatic test_release();
    bus.rptr_sync_in = 5'b00001;
    bus.wr_en_in = 1'b0;
    step();
    checks++;
    if (bus.wfull_out !== 1'b0 || bus.wr_count_out !== 5'd15) begin
      failures++;
      $display("FAIL release: full=%b cnt=%0d, want 0 15",
               bus.wfull_out, bus.wr_count_out);
    end
    bus.wr_en_in = 1'b1;
    #1;
    checks++;
    if (bus.wr_fire_out !== 1'b1 || bus.waddr_out !== 4'd0) begin
      failures++;
      $display("FAIL refill_addr: fire=%b waddr=%0d, want 1 0",
               bus.wr_fire_out, bus.waddr_out);
    end
    step();
    bus.wr_en_in = 1'b0;
    checks++;
    if (bus.wfull_out !== 1'b1 || bus.wr_count_out !== 5'd16 ||
        bus.wptr_out !== 5'b11001) begin
      failures++;
      $display("FAIL refill_full: full=%b cnt=%0d wptr=%b, want 1 16 11001",
               bus.wfull_out, bus.wr_count_out, bus.wptr_out);
    end
  endtask

  task automatic test_wrap();
    // wbin is 17, reader at 1; keep the reader 15 behind while stepping to 31
    bus.rptr_sync_in = g(2);
    bus.wr_en_in = 1'b0;
    step();
    bus.wr_en_in = 1'b1;
    for (int wb = 17; wb < 31; wb++) begin
      bus.rptr_sync_in = g(wb + 1 - 15);
      step();
      checks++;
      if (bus.wfull_out !== 1'b0 || bus.wr_count_out !== 5'd15 ||
          bus.wptr_out !== g(wb + 1)) begin
        failures++;
        $display("FAIL wrap_step[%0d]: full=%b cnt=%0d wptr=%b, want 0 15 %b",
                 wb, bus.wfull_out, bus.wr_count_out, bus.wptr_out, g(wb + 1));
      end
    end
    checks++;
    if (bus.wptr_out !== 5'b10000 || bus.waddr_out !== 4'd15) begin
      failures++;
      $display("FAIL wrap_pre: wptr=%b waddr=%0d, want 10000 15",
               bus.wptr_out, bus.waddr_out);
    end
    step();
    bus.wr_en_in = 1'b0;
    checks++;
    if (bus.wptr_out !== 5'b00000 || bus.wfull_out !== 1'b1 ||
        bus.wr_count_out !== 5'd16 || bus.waddr_out !== 4'd0) begin
      failures++;
      $display("FAIL wrap_full: wptr=%b full=%b cnt=%0d waddr=%0d, want 00000 1 16 0",
               bus.wptr_out, bus.wfull_out, bus.wr_count_out, bus.waddr_out);
    end
  endtask

  task automatic test_mid_reset();
    reset_n_in = 1'b0;
    #1;
    reset_n_in = 1'b1;
    bus.rptr_sync_in = 5'b00000;
    bus.wr_en_in = 1'b1;
    for (int i = 0; i < 7; i++)
      step();
    bus.wr_en_in = 1'b0;
    checks++;
    if (bus.waddr_out !== 4'd7 || bus.wr_count_out !== 5'd7) begin
      failures++;
      $display("FAIL midrst_pre: waddr=%0d cnt=%0d, want 7 7",
               bus.waddr_out, bus.wr_count_out);
    end
    #2;
    reset_n_in = 1'b0;
    #1;
    checks++;
    if (bus.waddr_out !== 4'd0 || bus.wptr_out !== 5'd0 ||
        bus.wr_count_out !== 5'd0) begin
      failures++;
      $display("FAIL midrst_async: waddr=%0d wptr=%b cnt=%0d, want 0 0 0",
               bus.waddr_out, bus.wptr_out, bus.wr_count_out);
    end
    step();
    reset_n_in = 1'b1;
    bus.wr_en_in = 1'b1;
    step();
    bus.wr_en_in = 1'b0;
    checks++;
    if (bus.waddr_out !== 4'd1 || bus.wptr_out !== 5'b00001 ||
        bus.wr_count_out !== 5'd1) begin
      failures++;
      $display("FAIL midrst_resume: waddr=%0d wptr=%b cnt=%0d, want 1 00001 1",
               bus.waddr_out, bus.wptr_out, bus.wr_count_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
